// File: rtl/bch_sys_encoder.sv
// Bit-serial systematic BCH encoder: the message passes through MSB-first, then the
// remainder of m(x)*x^PAR_LEN mod g(x) is appended MSB-first from the division LFSR.
module bch_sys_encoder #(
    parameter int                 DATA_LEN = 7,
    parameter int                 PAR_LEN  = 8,
    parameter logic [PAR_LEN-1:0] GEN_POLY = 8'hD1,
    parameter int                 CNT_W    = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_first,
    output logic out_last
);
    localparam logic [0:0] S_DATA   = 1'b0;
    localparam logic [0:0] S_PARITY = 1'b1;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] PAR_LAST  = CNT_W'(PAR_LEN - 1);

    logic [0:0]         state;
    logic [PAR_LEN-1:0] lfsr;
    logic [CNT_W-1:0]   count;

    logic               slot_free;
    logic               load_data;
    logic               load_par;
    logic               fb;
    logic [PAR_LEN-1:0] lfsr_div;

    // The output register is the only storage stage; a slot opens when it is empty or draining.
    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = (state == S_DATA) & slot_free;
    assign load_data = in_valid & in_ready;
    assign load_par  = (state == S_PARITY) & slot_free;

    assign fb       = in_bit ^ lfsr[PAR_LEN-1];
    assign lfsr_div = {lfsr[PAR_LEN-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_DATA;
            lfsr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_data) begin
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            out_first <= (count == '0);
            out_last  <= 1'b0;
            lfsr      <= lfsr_div;
            if (count == DATA_LAST) begin
                count <= '0;
                state <= S_PARITY;
            end else begin
                count <= count + 1'b1;
            end
        end else if (load_par) begin
            // Shifting out the remainder leaves the LFSR zeroed for the next codeword.
            out_bit   <= lfsr[PAR_LEN-1];
            out_valid <= 1'b1;
            out_first <= 1'b0;
            out_last  <= (count == PAR_LAST);
            lfsr      <= {lfsr[PAR_LEN-2:0], 1'b0};
            if (count == PAR_LAST) begin
                count <= '0;
                state <= S_DATA;
            end else begin
                count <= count + 1'b1;
            end
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bch_sys_encoder.sv
// Scoreboard bench for the BCH(15,7) encoder: expected codeword bits are queued at
// stimulus time and popped as the DUT hands bits downstream.
module tb_bch_sys_encoder;
    localparam int          DL = 7;
    localparam int          PL = 8;
    localparam logic [7:0]  GP = 8'hD1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, out_bit, out_first, out_last;

    int total = 0;
    int bad = 0;

    logic [2:0] exp_q[$];
    bit         rnd_ready = 1'b0;
    bit         mon_en = 1'b1;
    bit         acc;
    bit         s_in_ready;
    bit         s_last_vld;
    bit         pv_stall = 1'b0;
    logic [2:0] pv;
    int         run_len = 0;
    int         max_run = 0;

    always #5 clk = ~clk;

    bch_sys_encoder #(
        .DATA_LEN(DL),
        .PAR_LEN (PL),
        .GEN_POLY(GP),
        .CNT_W   (13)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_first(out_first),
        .out_last (out_last)
    );

    // Long-division reference: remainder of m(x)*x^8 divided by x^8+x^7+x^6+x^4+1.
    function automatic logic [7:0] sw_par(input logic [6:0] msg);
        logic [14:0] d;
        logic [14:0] g;
        d = {msg, 8'h00};
        g = 15'({1'b1, GP});
        for (int i = 14; i >= 8; i--)
            if (d[i]) d = d ^ (g << (i - 8));
        return d[7:0];
    endfunction

    task automatic push_cw(input logic [6:0] msg, input logic [7:0] par);
        for (int i = 6; i >= 0; i--) exp_q.push_back({msg[i], (i == 6), 1'b0});
        for (int j = 7; j >= 0; j--) exp_q.push_back({par[j], 1'b0, (j == 0)});
    endtask

    // One clock: sample/score at the falling edge, then move past the rising edge.
    task automatic tick();
        logic [2:0] cur;
        logic [2:0] e;
        @(negedge clk);
        acc        = in_valid && in_ready;
        s_in_ready = in_ready;
        s_last_vld = out_valid && out_last;
        cur        = {out_bit, out_first, out_last};
        if (rst_n) begin
            if (pv_stall) begin
                total++;
                if (!out_valid || cur !== pv) begin
                    bad++;
                    $display("FAIL hold: valid=%b bit/first/last=%b required 1 %b", out_valid, cur, pv);
                end
            end
            run_len = out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (out_valid && out_ready && mon_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_bit: bit/first/last=%b with empty scoreboard", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL codeword_bit: bit/first/last=%b required %b", cur, e);
                    end
                end
            end
            pv_stall = out_valid && !out_ready;
            pv       = cur;
        end
        @(posedge clk);
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_bits(input logic [6:0] msg, input int n, input bit gaps);
        int w;
        for (int i = 6; i > 6 - n; i--) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            in_valid = 1'b1;
            in_bit   = msg[i];
            w = 0;
            do begin
                tick();
                w++;
            end while (!acc && w < 100);
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: bit %0d not accepted in %0d cycles", i, w);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d bits outstanding, required 0", exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (out_bit !== 1'b0)   begin bad++; $display("FAIL rst_out_bit: got %b required 0", out_bit); end
        if (out_first !== 1'b0) begin bad++; $display("FAIL rst_out_first: got %b required 0", out_first); end
        if (out_last !== 1'b0)  begin bad++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        max_run = 0;
        push_cw(7'b1000000, 8'hE8);
        send_bits(7'b1000000, 7, 1'b0);
        wait_drain();
        total++;
        if (max_run != 15) begin bad++; $display("FAIL basic_run: got %0d valid cycles required 15", max_run); end
    endtask

    task automatic test_directed();
        push_cw(7'b0000001, 8'hD1);
        send_bits(7'b0000001, 7, 1'b0);
        wait_drain();
        push_cw(7'b1000001, 8'h39);
        send_bits(7'b1000001, 7, 1'b0);
        wait_drain();
        push_cw(7'b0000000, 8'h00);
        send_bits(7'b0000000, 7, 1'b0);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        max_run = 0;
        push_cw(7'b1000000, 8'hE8);
        push_cw(7'b0000001, 8'hD1);
        send_bits(7'b1000000, 7, 1'b0);
        send_bits(7'b0000001, 7, 1'b0);
        wait_drain();
        total++;
        if (max_run != 30) begin bad++; $display("FAIL b2b_run: got %0d valid cycles required 30", max_run); end
    endtask

    task automatic test_stall();
        int w = 0;
        rnd_ready = 1'b1;
        push_cw(7'b1000001, 8'h39);
        send_bits(7'b1000001, 7, 1'b0);
        // From the last message accept until the last parity bit is loaded, input must be blocked.
        do begin
            tick();
            w++;
            if (!s_last_vld) begin
                total++;
                if (s_in_ready !== 1'b0) begin bad++; $display("FAIL parity_in_ready: got %b required 0", s_in_ready); end
            end
        end while (!s_last_vld && w < 200);
        wait_drain();
        rnd_ready = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        mon_en = 1'b0;
        send_bits(7'b1011000, 4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
        if (out_first !== 1'b0) begin bad++; $display("FAIL mid_rst_first: got %b required 0", out_first); end
        if (out_last !== 1'b0)  begin bad++; $display("FAIL mid_rst_last: got %b required 0", out_last); end
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_rst_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        pv_stall = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        push_cw(7'b0000001, 8'hD1);
        send_bits(7'b0000001, 7, 1'b0);
        wait_drain();
    endtask

    task automatic test_random();
        logic [6:0] msg;
        rnd_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            msg = 7'($urandom());
            push_cw(msg, sw_par(msg));
            send_bits(msg, 7, 1'b1);
        end
        wait_drain();
        rnd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bch_sys_encoder.md
Name: bch_sys_encoder

Overview:
- Bit-serial systematic BCH encoder; the transmit-side counterpart of the Euclidean-algorithm BCH decoder datapath.
- Accepts DATA_LEN message bits MSB-first and passes them through unchanged.
- Then appends PAR_LEN parity bits, the remainder of m(x)·x^PAR_LEN mod g(x), MSB-first.
- The LFSR division over GF(2) produces the codeword format the decoder's syndrome stage consumes.
- Defaults describe BCH(15,7), t=2, for bench closure. Production instantiates the GF(2^13) code (PAR_LEN=13·t).

Parameters:
- DATA_LEN, 7: message bits per codeword (k); must be ≥1.
- PAR_LEN, 8: parity bits (n−k); must be ≥2.
- GEN_POLY, 8'hD1: g(x) coefficients x^(PAR_LEN−1)..x^0. The leading x^PAR_LEN term is implicit. Width PAR_LEN.
- CNT_W, 13: width of the internal bit counter; must satisfy 2^CNT_W > max(DATA_LEN, PAR_LEN).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: message bit valid.
- in_ready, output, 1: encoder accepts a message bit this cycle.
- in_bit, input, 1: message bit, MSB (highest-degree coefficient) first.
- out_valid, output, 1: codeword bit valid.
- out_ready, input, 1: downstream accepts the codeword bit.
- out_bit, output, 1: codeword bit.
- out_first, output, 1: marks codeword bit 0 (first message bit).
- out_last, output, 1: marks the final parity bit.

Behaviour:
- Reset (async assert, sync release):
  - state=DATA, lfsr=0, count=0.
  - out_valid=0, out_bit=0, out_first=0, out_last=0.
  - in_ready follows its combinational equation (1 after reset).
- Output register: single stage.
  - out_take = out_valid & out_ready.
  - slot_free = ~out_valid | out_ready.
  - When slot_free is set and no new bit is loaded, out_valid clears on that edge.
- States:
  - DATA: in_ready = slot_free. A message bit is accepted on in_valid & in_ready.
    - out_bit ← in_bit; out_valid ← 1; out_first ← (count==0); out_last ← 0.
    - fb = in_bit ^ lfsr[PAR_LEN−1].
    - lfsr ← {lfsr[PAR_LEN−2:0],0} ^ (fb ? GEN_POLY : 0).
    - count ← count+1.
    - On the DATA_LEN-th accept: count ← 0, state ← PARITY.
  - PARITY: in_ready = 0. When slot_free is set:
    - out_bit ← lfsr[PAR_LEN−1]; out_valid ← 1; out_first ← 0.
    - lfsr ← lfsr<<1, zero-filled; count ← count+1.
    - out_last ← (count==PAR_LEN−1).
    - After loading the PAR_LEN-th parity bit: count ← 0, state ← DATA. The lfsr is all-zero at that point by the shifting.
- Latency: each input bit appears on out_bit on the cycle after acceptance.
- Throughput: one bit per cycle when out_ready is held high.
  - No bubble between the last message bit and the first parity bit.
  - No bubble between the last parity bit and the next codeword's first bit when in_valid is high.
- Backpressure: while out_valid & ~out_ready, out_bit, out_first and out_last hold stable, and lfsr and count are frozen.
- in_valid low in DATA: lfsr and count hold. The frame resumes when in_valid returns; there is no timeout.
- Reset mid-frame: the partial codeword is discarded with no out_last; the next accepted bit starts a new codeword with out_first=1.
- Simultaneous out_take and new load in the same cycle is allowed and is the normal streaming case.

Test Plan:
- Reset, then stream message 1000000 with out_ready=1 → out_bit = 1,0,0,0,0,0,0 then parity 1,1,1,0,1,0,0,0; out_first on bit 0, out_last on bit 14; 15 consecutive out_valid cycles.
- Message 0000001 → parity 11010001 (=GEN_POLY). Message 1000001 → parity 00111001 (linearity check).
- All-zero message → parity 00000000. Two back-to-back codewords (1000000 then 0000001) with in_valid held high → no gap; second codeword's out_first immediately follows first's out_last; parities E8 then D1.
- Random out_ready toggling (~50%) during message 1000001 → bit sequence identical to the unstalled run; out_bit/out_first/out_last stable while stalled; in_ready=0 throughout PARITY.
- Assert rst_n low after 4 message bits, release, then send 0000001 → outputs clear asynchronously; new codeword is correct (parity D1), with out_first on its first bit.
- Random messages (≥1000) checked against a software polynomial-division model; in_valid gaps inserted → all parities match.
